one_to_two_router: RTL

- Splits one 16-bit valid/ready stream into two output channels, steered per beat by a select bit.
- This is the inverse of the datapath's 2:1 select: one source fans out to two sinks, e.g. writeback steering between the register-file port and the store port.
- Each output channel has its own small FIFO, so a stalled sink does not block beats destined for the other sink.
- Order is preserved within each channel.

---
 rtl/one_to_two_router_pkg.sv | 22 ++
 rtl/one_to_two_router_fifo.sv | 67 ++++++
 rtl/one_to_two_router.sv | 82 ++++++++
 3 files changed

// File: rtl/one_to_two_router_pkg.sv
// ============================================================================
// Package : router_pkg
// Brief   : Shared widths and types for the one-to-two stream router.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package router_pkg;

    localparam int ROUTER_WIDTH = 16;
    localparam int ROUTER_DEPTH = 2;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } route_sel_t;

    typedef logic [ROUTER_WIDTH-1:0] router_word_t;

endpackage

`default_nettype wire

// File: rtl/one_to_two_router_fifo.sv
// ============================================================================
// Module : route_fifo
// Brief  : Small synchronous FIFO for one router output channel; head is 0 when empty.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module route_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     occ,
    output logic [WIDTH-1:0]           head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (occ == OCC_W'(DEPTH));
    assign empty   = (occ == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = storage[rd_ptr];

    // Popped slots are zeroed so the head reads 0 whenever the FIFO is empty.
    // A push and a pop never target the same slot: that needs occ==0 or occ==DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else begin
            if (pop_ok) begin
                storage[rd_ptr] <= '0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                storage[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/one_to_two_router.sv
// ============================================================================
// Module : one_to_two_router
// Brief  : Steers one valid/ready stream into two independently buffered channels.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module one_to_two_router
    import router_pkg::*;
#(
    parameter int WIDTH = ROUTER_WIDTH,
    parameter int DEPTH = ROUTER_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_sel,
    output logic                       out0_valid,
    input  logic                       out0_ready,
    output logic [WIDTH-1:0]           out0_data,
    output logic                       out1_valid,
    input  logic                       out1_ready,
    output logic [WIDTH-1:0]           out1_data,
    output logic [$clog2(DEPTH):0]     occ0,
    output logic [$clog2(DEPTH):0]     occ1
);

    route_sel_t sel;
    logic       full0;
    logic       full1;
    logic       empty0;
    logic       empty1;
    logic       accept;
    logic       push0;
    logic       push1;

    assign sel = route_sel_t'(in_sel);

    // Ready depends only on the selected FIFO's registered fullness, never on a same-cycle pop.
    assign in_ready = (sel == CH1) ? ~full1 : ~full0;
    assign accept   = in_valid & in_ready;
    assign push0    = accept & (sel == CH0);
    assign push1    = accept & (sel == CH1);

    assign out0_valid = ~empty0;
    assign out1_valid = ~empty1;

    route_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_ch0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (in_data),
        .pop       (out0_ready),
        .full      (full0),
        .empty     (empty0),
        .occ       (occ0),
        .head      (out0_data)
    );

    route_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_ch1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (in_data),
        .pop       (out1_ready),
        .full      (full1),
        .empty     (empty1),
        .occ       (occ1),
        .head      (out1_data)
    );

endmodule

`default_nettype wire
